// File: rtl/instr_decode_queue_pkg.sv
// Shared RV32I decode types, opcode and exception constants, and the pure
// decode helpers (instruction name/format and immediate formation).
// Ports: none (package).
package instr_decode_queue_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] EXC_INSTR_MISALIGNED = 32'd0;
  localparam logic [31:0] EXC_ILLEGAL          = 32'd2;
  localparam logic [31:0] EXC_BREAKPOINT       = 32'd3;
  localparam logic [31:0] EXC_ECALL_M          = 32'd11;

  typedef enum logic [5:0] {
    instr_lui, instr_auipc, instr_jal, instr_jalr,
    instr_beq, instr_bne, instr_blt, instr_bge, instr_bltu, instr_bgeu,
    instr_lb, instr_lh, instr_lw, instr_lbu, instr_lhu,
    instr_sb, instr_sh, instr_sw,
    instr_addi, instr_slti, instr_sltiu, instr_xori, instr_ori, instr_andi,
    instr_slli, instr_srli, instr_srai,
    instr_add, instr_sub, instr_sll, instr_slt, instr_sltu,
    instr_xor, instr_srl, instr_sra, instr_or, instr_and,
    instr_fence, instr_fence_i, instr_ecall, instr_ebreak,
    instr_csrrw, instr_csrrs, instr_csrrc,
    instr_csrrwi, instr_csrrsi, instr_csrrci,
    instr_illegal
  } instr_e;

  typedef enum logic [2:0] {
    instr_type_R, instr_type_I, instr_type_S, instr_type_SB,
    instr_type_U, instr_type_UJ, instr_type_X
  } instr_type_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } decoded_instr_t;

  typedef struct packed {
    instr_e      name;
    instr_type_t typ;
  } op_info_t;

  function automatic logic [31:0] get_imm(input logic [31:0] instr, input instr_type_t typ);
    logic [31:0] imm;
    case (typ)
      instr_type_I:  imm = {{20{instr[31]}}, instr[31:20]};
      instr_type_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      instr_type_SB: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      instr_type_U:  imm = {instr[31:12], 12'b0};
      instr_type_UJ: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:       imm = 32'd0;
    endcase
    return imm;
  endfunction

  // Name and format of one raw instruction. Anything not recognised comes
  // back as instr_illegal with format X; sys_en=0 makes SYSTEM and MISC-MEM
  // opcodes unknown.
  function automatic op_info_t decode_op(input logic [31:0] instr, input logic sys_en);
    op_info_t   info;
    logic [2:0] f3;
    logic [6:0] f7;
    f3        = instr[14:12];
    f7        = instr[31:25];
    info.name = instr_illegal;
    info.typ  = instr_type_I;
    case (instr[6:0])
      OPC_LUI:   begin info.typ = instr_type_U;  info.name = instr_lui;   end
      OPC_AUIPC: begin info.typ = instr_type_U;  info.name = instr_auipc; end
      OPC_JAL:   begin info.typ = instr_type_UJ; info.name = instr_jal;   end
      OPC_JALR:  if (f3 == 3'b000) info.name = instr_jalr;
      OPC_BRANCH: begin
        info.typ = instr_type_SB;
        case (f3)
          3'b000: info.name = instr_beq;
          3'b001: info.name = instr_bne;
          3'b100: info.name = instr_blt;
          3'b101: info.name = instr_bge;
          3'b110: info.name = instr_bltu;
          3'b111: info.name = instr_bgeu;
          default: ;
        endcase
      end
      OPC_LOAD: begin
        case (f3)
          3'b000: info.name = instr_lb;
          3'b001: info.name = instr_lh;
          3'b010: info.name = instr_lw;
          3'b100: info.name = instr_lbu;
          3'b101: info.name = instr_lhu;
          default: ;
        endcase
      end
      OPC_STORE: begin
        info.typ = instr_type_S;
        case (f3)
          3'b000: info.name = instr_sb;
          3'b001: info.name = instr_sh;
          3'b010: info.name = instr_sw;
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        case (f3)
          3'b000: info.name = instr_addi;
          3'b010: info.name = instr_slti;
          3'b011: info.name = instr_sltiu;
          3'b100: info.name = instr_xori;
          3'b110: info.name = instr_ori;
          3'b111: info.name = instr_andi;
          3'b001: if (f7 == 7'b0000000) info.name = instr_slli;
          default: begin
            if (f7 == 7'b0000000)      info.name = instr_srli;
            else if (f7 == 7'b0100000) info.name = instr_srai;
          end
        endcase
      end
      OPC_OP: begin
        info.typ = instr_type_R;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  info.name = instr_add;
            3'b001:  info.name = instr_sll;
            3'b010:  info.name = instr_slt;
            3'b011:  info.name = instr_sltu;
            3'b100:  info.name = instr_xor;
            3'b101:  info.name = instr_srl;
            3'b110:  info.name = instr_or;
            default: info.name = instr_and;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      info.name = instr_sub;
          else if (f3 == 3'b101) info.name = instr_sra;
        end
      end
      OPC_MISC_MEM: begin
        if (sys_en && f3 == 3'b000)      info.name = instr_fence;
        else if (sys_en && f3 == 3'b001) info.name = instr_fence_i;
      end
      OPC_SYSTEM: begin
        if (sys_en) begin
          case (f3)
            3'b000: begin
              // Only the exact ECALL/EBREAK encodings; MRET/WFI etc. are not supported.
              if (instr == 32'h0000_0073)      info.name = instr_ecall;
              else if (instr == 32'h0010_0073) info.name = instr_ebreak;
            end
            3'b001: info.name = instr_csrrw;
            3'b010: info.name = instr_csrrs;
            3'b011: info.name = instr_csrrc;
            3'b101: info.name = instr_csrrwi;
            3'b110: info.name = instr_csrrsi;
            3'b111: info.name = instr_csrrci;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
    if (info.name == instr_illegal) info.typ = instr_type_X;
    return info;
  endfunction

endpackage

// File: rtl/instr_decode_queue_fifo.sv
// Generic circular FIFO holding {pc, instr} entries for the decode queue.
// Latency: written entry visible at head one edge after push; head read is combinational.
// Backpressure: none internally; caller must not push when full or pop when empty.
// Ports: clk/rst_n, flush_i clears, push_i/push_dat_i write, pop_i advances head,
//        head_dat_o oldest entry, count_o occupancy.
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered RV32I decode stage: FIFO of raw instructions, head decoded into a registered output slot.
// Latency: 2 cycles accept-to-output (FIFO edge, then slot edge), no bypass; 1 instr/cycle sustained.
// Backpressure: in_ready_o from registered count only; slot holds stable while out_valid_o && !out_ready_i.
// Ports: in_* upstream valid/ready + instr/pc, out_* decoded slot with valid/ready,
//        flush_i synchronous clear, count_o FIFO occupancy (slot not included).
module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit SYSTEM_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [31:0]                in_pc_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output decoded_instr_t             out_dec_o,
  output instr_e                     out_name_o,
  output instr_type_t                out_type_o,
  output logic [31:0]                out_imm_o,
  output logic [31:0]                out_pc_o,
  output logic                       out_exc_o,
  output logic [31:0]                out_cause_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]  count;
  logic [63:0]    head_dat;
  logic [31:0]    head_instr, head_pc;
  logic           push, pop, slot_en;

  op_info_t       info;
  decoded_instr_t new_dec;
  logic           new_exc;
  logic [31:0]    new_cause;

  logic           valid_q, valid_d;
  decoded_instr_t dec_q, dec_d;
  instr_e         name_q, name_d;
  instr_type_t    type_q, type_d;
  logic [31:0]    pc_q, pc_d;
  logic           exc_q, exc_d;
  logic [31:0]    cause_q, cause_d;

  assign in_ready_o = (count < CW'(DEPTH)) && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign slot_en    = !valid_q || out_ready_i;
  assign pop        = slot_en && (count != '0) && !flush_i;

  decode_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .push_i     (push),
    .push_dat_i ({in_pc_i, in_instr_i}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (count)
  );

  assign head_instr = head_dat[31:0];
  assign head_pc    = head_dat[63:32];

  // Decode of the FIFO head; only registered when it is popped.
  always_comb begin
    info           = decode_op(head_instr, SYSTEM_EN);
    new_dec.opcode = head_instr[6:0];
    new_dec.imm    = get_imm(head_instr, info.typ);
    new_dec.funct3 = head_instr[14:12];
    new_dec.funct7 = head_instr[31:25];
    new_dec.rs1    = head_instr[19:15];
    new_dec.rs2    = head_instr[24:20];
    new_dec.rd     = head_instr[11:7];
    new_exc        = 1'b0;
    new_cause      = 32'd0;
    // A misaligned fetch outranks anything the instruction bits say.
    if (head_pc[1:0] != 2'b00) begin
      new_exc   = 1'b1;
      new_cause = EXC_INSTR_MISALIGNED;
    end else if (info.name == instr_illegal) begin
      new_exc   = 1'b1;
      new_cause = EXC_ILLEGAL;
    end else if (info.name == instr_ecall) begin
      new_exc   = 1'b1;
      new_cause = EXC_ECALL_M;
    end else if (info.name == instr_ebreak) begin
      new_exc   = 1'b1;
      new_cause = EXC_BREAKPOINT;
    end
  end

  // Output slot: data only changes on a pop, so it holds while stalled and
  // simply keeps stale contents when it drains to invalid.
  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    name_d  = name_q;
    type_d  = type_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    cause_d = cause_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (slot_en) begin
      valid_d = pop;
      if (pop) begin
        dec_d   = new_dec;
        name_d  = info.name;
        type_d  = info.typ;
        pc_d    = head_pc;
        exc_d   = new_exc;
        cause_d = new_cause;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      name_q  <= instr_lui;
      type_q  <= instr_type_R;
      pc_q    <= 32'd0;
      exc_q   <= 1'b0;
      cause_q <= 32'd0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      name_q  <= name_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_dec_o   = dec_q;
  assign out_name_o  = name_q;
  assign out_type_o  = type_q;
  assign out_imm_o   = dec_q.imm;
  assign out_pc_o    = pc_q;
  assign out_exc_o   = exc_q;
  assign out_cause_o = cause_q;
  assign count_o     = count;

endmodule
